pe_window_feeder: RTL
=====================

# pe_window_feeder

Streaming front-end for the 1-D convolution processing element. Accepts 2-bit samples one per cycle over a valid/ready handshake and packs them into 8-sample overlapping windows. Each window is presented together with a snapshot of the 3-tap filter as one packed word on a valid/ready output. This is the producer for the PE's `in`/`filter` inputs. Consecutive windows overlap by TAPS-1 samples so the PE's outputs tile the input stream with no gaps.

## Interface
- DW, 2, sample and filter-tap width in bits
- WIN, 8, samples per window
- TAPS, 3, filter taps; stride = WIN-TAPS+1 (6), overlap = TAPS-1 (2)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset: one clock, reset is synchronous and active-low
- s_valid  in  1  input sample valid
- s_ready  out  1  feeder can accept a sample
- s_data  in  DW  input sample
- s_last  in  1  final sample of a stream (used only with flush feature)
- f_load  in  1  load new filter taps this cycle
- f_data  in  DW*TAPS  taps; tap k in [DW*k+DW-1:DW*k]
- w_valid  out  1  window valid
- w_ready  in  1  PE side accepts window
- w_in  out  DW*WIN  packed window; sample k in [DW*k+DW-1:DW*k], sample 0 oldest
- w_filter  out  DW*TAPS  filter snapshot for this window
- w_last  out  1  window is the last of a stream

## Operation
- States: FILL (s_ready=1, collecting samples) and HOLD (w_valid=1, s_ready=0).
- FILL: on s_valid&&s_ready, sample written at slot `cnt`, `cnt`++. When slot WIN-1 is written, go to HOLD and latch the filter snapshot.
- HOLD: w_in, w_filter and w_last are stable while w_ready=0. On w_ready:
  - slots WIN-2..WIN-1 are copied to slots 0..1 and the remaining slots are zeroed;
  - `cnt` = TAPS-1; return to FILL.
- Filter: an f_load pulse updates the internal tap register in any state. The snapshot is taken at the FILL->HOLD transition. If f_load occurs in that same cycle, the new taps are captured. An f_load during HOLD does not change the w_filter currently presented.
- First window after reset or after a flush needs WIN samples. Each later window needs stride (6) samples.
- Arithmetic: none; pure packing. Widths are derived from parameters only.
- Reset: state=FILL, cnt=0, window=0, taps=0, s_ready=1 from the first cycle after reset, w_valid=0, w_in=0, w_filter=0, w_last=0.
- Reset asserted mid-fill or during HOLD discards the partial or pending window; no output is emitted.

## Timing
- Window completion: the WIN-th (or stride-th) sample accepted at edge N gives w_valid=1 after edge N, with s_ready=0 in the same cycle.
- Handshake completion: w_valid&&w_ready at edge M gives s_ready=1 and w_valid=0 after M.
- Minimum spacing between windows is stride+1 cycles (6 fill, 1 hold).
- s_ready does not depend combinationally on w_ready; no combinational path from input to output.

## Configuration
- PE_FEED_FLUSH_EN defined:
  - accepting a sample with s_last=1 forces the transition to HOLD;
  - unfilled slots above the last sample are zero-padded and w_last=1;
  - after the handshake, cnt=0 and the window is cleared (no overlap carried).
  - If the last sample also fills slot WIN-1, the window is identical to a normal one but with w_last=1.
- PE_FEED_FLUSH_EN undefined: s_last is ignored, w_last is tied 0, and a trailing partial window is held until further samples arrive.

## Structure
- Shared package `pe_pkg` holds DW/WIN/TAPS defaults, the derived STRIDE/OVL constants and the FSM state enum (FILL, HOLD).
- One sub-module, `pe_win_shiftreg`: the WIN-slot sample register with indexed write, overlap-shift and clear. The FSM, counter and filter snapshot stay in the top.

## Test plan
- Basic window: after reset, taps 6'b010101, samples 1,2,3,0,1,2,3,0, w_ready=1 -> one window w_in=16'h3939, w_filter=6'h15, w_valid high exactly 1 cycle.
- Overlap: continue with six samples of 1 -> w_in=16'h5553 (old samples 3,0 in slots 0–1).
- Backpressure: w_ready=0 for 5 cycles during HOLD -> w_in/w_filter stable, s_ready=0 throughout; the drive with s_valid=1 is not consumed.
- Filter timing: f_load 6'h3F after sample 4 of a fill -> that window has w_filter=6'h3F. f_load 6'h00 during HOLD -> current w_filter unchanged, next window has 6'h00.
- Flush (PE_FEED_FLUSH_EN): after reset, samples 1,2,3 with s_last on the 3 -> w_in=16'h0039, w_last=1. The next window needs 8 fresh samples.
- Reset mid-operation: rst_n low for 1 cycle after 5 samples -> no window emitted. The next 8 samples produce a window containing only the new data.

Source files
------------

// File: rtl/pe_pkg.sv
// pe_pkg: shared constants and types for the 1-D convolution PE window feeder.
//   DW     - sample / filter-tap width in bits
//   WIN    - samples per window
//   TAPS   - filter taps
//   STRIDE - fresh samples needed per window after the first (WIN-TAPS+1)
//   OVL    - samples carried from one window into the next (TAPS-1)
//   state_e - feeder FSM state (FILL collects samples, HOLD presents a window)
package pe_pkg;
  localparam int DW     = 2;
  localparam int WIN    = 8;
  localparam int TAPS   = 3;
  localparam int STRIDE = WIN - TAPS + 1;
  localparam int OVL    = TAPS - 1;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;
endpackage

// File: rtl/pe_win_shiftreg.sv
// pe_win_shiftreg: WIN-slot sample register for the window feeder.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset (all slots cleared)
//   wr_en_i     - write wr_data_i into slot wr_idx_i
//   wr_idx_i    - slot index for the write
//   wr_data_i   - sample to write
//   shift_i     - overlap shift: top OVL slots move to slots 0..OVL-1, rest zeroed
//   clr_i       - clear every slot
//   win_o       - packed window, slot k in [DW*k +: DW], slot 0 oldest
// Priority when several controls are active: clear, then shift, then write.
module pe_win_shiftreg #(
  parameter int DW  = 2,
  parameter int WIN = 8,
  parameter int OVL = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en_i,
  input  logic [$clog2(WIN)-1:0] wr_idx_i,
  input  logic [DW-1:0]          wr_data_i,
  input  logic                   shift_i,
  input  logic                   clr_i,
  output logic [DW*WIN-1:0]      win_o
);
  logic [DW-1:0] slot_q [WIN];
  logic [DW-1:0] slot_d [WIN];

  always_comb begin
    for (int i = 0; i < WIN; i++) slot_d[i] = slot_q[i];
    if (clr_i) begin
      for (int i = 0; i < WIN; i++) slot_d[i] = '0;
    end else if (shift_i) begin
      // The newest OVL samples become the oldest of the next window.
      for (int i = 0; i < OVL; i++) slot_d[i] = slot_q[WIN-OVL+i];
      for (int i = OVL; i < WIN; i++) slot_d[i] = '0;
    end else if (wr_en_i) begin
      slot_d[wr_idx_i] = wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN; i++) slot_q[i] <= '0;
    end else begin
      for (int i = 0; i < WIN; i++) slot_q[i] <= slot_d[i];
    end
  end

  always_comb begin
    win_o = '0;
    for (int k = 0; k < WIN; k++) win_o[DW*k +: DW] = slot_q[k];
  end
endmodule

// File: rtl/pe_window_feeder.sv
// pe_window_feeder: packs a stream of DW-bit samples into WIN-sample windows
// overlapping by TAPS-1 samples, each paired with a snapshot of the filter taps.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   s_valid/s_ready     - sample handshake, s_data sample, s_last end of stream
//   f_load/f_data       - load new taps (tap k in [DW*k +: DW]) in any state
//   w_valid/w_ready     - window handshake; w_in packed window (slot 0 oldest),
//                         w_filter tap snapshot, w_last final window of a stream
//   dbg_state_o         - current FSM state, for observation only
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; valid never depends on ready, and payload is held stable while
// valid && !ready. s_ready and w_valid come straight from the state register.
// Optional feature: define PE_FEED_FLUSH_EN to make s_last close a partial
// window (zero padded, w_last=1, no overlap carried). Without it s_last is
// ignored and w_last stays 0.
module pe_window_feeder
  import pe_pkg::*;
#(
  parameter int DW   = pe_pkg::DW,
  parameter int WIN  = pe_pkg::WIN,
  parameter int TAPS = pe_pkg::TAPS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DW-1:0]      s_data,
  input  logic               s_last,
  input  logic               f_load,
  input  logic [DW*TAPS-1:0] f_data,
  output logic               w_valid,
  input  logic               w_ready,
  output logic [DW*WIN-1:0]  w_in,
  output logic [DW*TAPS-1:0] w_filter,
  output logic               w_last,
  output state_e             dbg_state_o
);
  localparam int CNT_W  = $clog2(WIN);
  localparam int OVL_SZ = TAPS - 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DW*TAPS-1:0] taps_q;
  logic [DW*TAPS-1:0] snap_q, snap_d;
  logic               last_q, last_d;
  logic               flush_hit;
  logic               wr_en, shift_en, clr_en;

`ifdef PE_FEED_FLUSH_EN
  assign flush_hit = s_last;
`else
  logic unused_s_last;
  assign unused_s_last = s_last;
  assign flush_hit     = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    snap_d   = snap_q;
    last_d   = last_q;
    wr_en    = 1'b0;
    shift_en = 1'b0;
    clr_en   = 1'b0;
    case (state_q)
      FILL: begin
        if (s_valid) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIN-1) || flush_hit) begin
            state_d = HOLD;
            // Taps loaded in this very cycle win over the stored taps.
            snap_d  = f_load ? f_data : taps_q;
            last_d  = flush_hit;
          end
        end
      end
      HOLD: begin
        if (w_ready) begin
          state_d = FILL;
          last_d  = 1'b0;
          if (last_q) begin
            // End of stream: next window starts from an empty register.
            clr_en = 1'b1;
            cnt_d  = '0;
          end else begin
            shift_en = 1'b1;
            cnt_d    = CNT_W'(OVL_SZ);
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      cnt_q   <= '0;
      taps_q  <= '0;
      snap_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      last_q  <= last_d;
      if (f_load) taps_q <= f_data;
    end
  end

  pe_win_shiftreg #(
    .DW  (DW),
    .WIN (WIN),
    .OVL (OVL_SZ)
  ) u_shiftreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en),
    .wr_idx_i  (cnt_q),
    .wr_data_i (s_data),
    .shift_i   (shift_en),
    .clr_i     (clr_en),
    .win_o     (w_in)
  );

  assign s_ready     = (state_q == FILL);
  assign w_valid     = (state_q == HOLD);
  assign w_filter    = snap_q;
  assign w_last      = last_q;
  assign dbg_state_o = state_q;
endmodule
